// File: rtl/disp_pkg.sv
// Shared types and constants for the dashboard display scheduler:
// FSM encoding, request/grant source indices and 7-segment glyphs.
package disp_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int SRC_MILE  = 0;
    localparam int SRC_SPEED = 1;
    localparam int SRC_ALERT = 2;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high, dp never lit.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/disp_sched_if.sv
// Request/grant and display bus between the dashboard sources and the scheduler.
// Handshake: req bits are levels held by each source while it wants the display;
// gnt is a registered one-hot answer, a source owns the display while its gnt bit is high.
interface disp_sched_if;
    import disp_pkg::*;

    logic        tick;
    logic [1:0]  mode;
    logic [2:0]  req;
    logic [11:0] bcd_mile;
    logic [11:0] bcd_speed;
    logic [11:0] bcd_alert;
    logic [2:0]  gnt;
    logic [7:0]  led_seg;
    logic [2:0]  an;
    state_t      dbg_state;

    modport master (
        output tick, mode, req, bcd_mile, bcd_speed, bcd_alert,
        input  gnt, led_seg, an, dbg_state
    );

    modport slave (
        input  tick, mode, req, bcd_mile, bcd_speed, bcd_alert,
        output gnt, led_seg, an, dbg_state
    );

endinterface

// File: rtl/disp_sched_seg_decode.sv
// BCD nibble to 7-segment glyph; non-decimal nibbles render blank.
module seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: arbitrates mileage/speed/alert for one 3-digit display,
// holds each grant for a minimum tick count and multiplexes the digits.
module disp_sched
    import disp_pkg::*;
#(
    parameter int HOLD_TICKS = 500,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    disp_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'((HOLD_TICKS == 0) ? 1 : HOLD_TICKS);

    state_t           state_q, state_n;
    logic [2:0]       gnt_q, gnt_n, win;
    logic [11:0]      shadow_q, shadow_n;
    logic [CNT_W-1:0] hold_q, hold_n;
    logic [1:0]       scan_q, scan_n;
    logic             rr_q, rr_n;
    logic             grant_new, car_on;
    logic [2:0]       an_q, an_n;
    logic [7:0]       seg_q, seg_n, seg_raw;
    logic [3:0]       nib;
    logic             lz_blank;

    assign car_on = (bus.mode != 2'b00);

    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        shadow_n  = shadow_q;
        hold_n    = hold_q;
        scan_n    = scan_q;
        rr_n      = rr_q;
        grant_new = 1'b0;
        win       = 3'b000;
        unique case (state_q)
            OFF: begin
                if (car_on) state_n = IDLE;
            end
            IDLE: begin
                if (!car_on) begin
                    state_n = OFF;
                end else if (bus.req != 3'b000) begin
                    grant_new = 1'b1;
                    if (bus.req[SRC_ALERT])      win = 3'b100;
                    else if (bus.req[SRC_SPEED]) win = 3'b010;
                    else                         win = 3'b001;
                end
            end
            SHOW: begin
                if (!car_on) begin
                    state_n = OFF;
                    gnt_n   = 3'b000;
                end else if (bus.req[SRC_ALERT] && !gnt_q[SRC_ALERT]) begin
                    grant_new = 1'b1;
                    win       = 3'b100;
                end else if (hold_q == HOLD_MAX) begin
                    // rr_q remembers the last non-alert source so the one after an alert alternates
                    if (bus.req[SRC_ALERT])
                        win = 3'b100;
                    else if (gnt_q[SRC_SPEED] && bus.req[SRC_MILE])
                        win = 3'b001;
                    else if (gnt_q[SRC_MILE] && bus.req[SRC_SPEED])
                        win = 3'b010;
                    else if (gnt_q[SRC_ALERT] && (bus.req[SRC_MILE] || bus.req[SRC_SPEED]))
                        win = (bus.req[SRC_MILE] && (rr_q || !bus.req[SRC_SPEED])) ? 3'b001 : 3'b010;
                    else if ((bus.req & gnt_q) != 3'b000)
                        win = gnt_q;
                    if (win != 3'b000) begin
                        grant_new = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 3'b000;
                    end
                end else if (bus.tick) begin
                    hold_n = hold_q + CNT_W'(1);
                    scan_n = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
                    // a source that has withdrawn keeps its last value frozen
                    if ((bus.req & gnt_q) != 3'b000)
                        shadow_n = gnt_q[SRC_ALERT] ? bus.bcd_alert :
                                   gnt_q[SRC_SPEED] ? bus.bcd_speed : bus.bcd_mile;
                end
            end
            default: begin
                state_n = OFF;
                gnt_n   = 3'b000;
            end
        endcase
        if (grant_new) begin
            state_n  = SHOW;
            gnt_n    = win;
            shadow_n = win[SRC_ALERT] ? bus.bcd_alert :
                       win[SRC_SPEED] ? bus.bcd_speed : bus.bcd_mile;
            hold_n   = '0;
            scan_n   = 2'd0;
            if (!win[SRC_ALERT]) rr_n = win[SRC_SPEED];
        end
    end

    // Digit outputs are decoded from the next-state values so they register alongside gnt.
    always_comb begin
        nib      = shadow_n[3:0];
        lz_blank = 1'b0;
        case (scan_n)
            2'd1: begin
                nib      = shadow_n[7:4];
                lz_blank = (shadow_n[11:4] == 8'd0);
            end
            2'd2: begin
                nib      = shadow_n[11:8];
                lz_blank = (shadow_n[11:8] == 4'd0);
            end
            default: ;
        endcase
        an_n  = (state_n == SHOW) ? (3'b001 << scan_n) : 3'b000;
        seg_n = ((state_n == SHOW) && !lz_blank) ? seg_raw : 8'h00;
    end

    seg_decode u_seg (
        .bcd (nib),
        .seg (seg_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF;
            gnt_q    <= 3'b000;
            shadow_q <= 12'h000;
            hold_q   <= '0;
            scan_q   <= 2'd0;
            rr_q     <= 1'b0;
            an_q     <= 3'b000;
            seg_q    <= 8'h00;
        end else begin
            state_q  <= state_n;
            gnt_q    <= gnt_n;
            shadow_q <= shadow_n;
            hold_q   <= hold_n;
            scan_q   <= scan_n;
            rr_q     <= rr_n;
            an_q     <= an_n;
            seg_q    <= seg_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.an        = an_q;
    assign bus.led_seg   = seg_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched: cycle table through the main scenarios, then
// hand sequences for asynchronous reset and the HOLD_TICKS=0 boundary.
module tb_disp_sched;
  import disp_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  disp_sched_if bus();
  disp_sched_if bus0();

  disp_sched #(.HOLD_TICKS(4), .CNT_W(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  disp_sched #(.HOLD_TICKS(0), .CNT_W(10)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.tick      = bus.tick;
  assign bus0.mode      = bus.mode;
  assign bus0.req       = bus.req;
  assign bus0.bcd_mile  = bus.bcd_mile;
  assign bus0.bcd_speed = bus.bcd_speed;
  assign bus0.bcd_alert = bus.bcd_alert;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [1:0]  mode;
    logic [2:0]  req;
    logic [11:0] mile;
    logic [11:0] speed;
    logic [11:0] alert;
    logic [2:0]  gnt;
    logic [2:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];

  task automatic add(input logic t, input logic [1:0] m, input logic [2:0] r,
                     input logic [11:0] mi, input logic [11:0] sp, input logic [11:0] al,
                     input logic [2:0] g, input logic [2:0] a, input logic [7:0] s);
    vec_t v;
    v.tick = t; v.mode = m; v.req = r; v.mile = mi; v.speed = sp; v.alert = al;
    v.gnt = g; v.an = a; v.seg = s;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic t, input logic [1:0] m, input logic [2:0] r,
                       input logic [11:0] mi, input logic [11:0] sp, input logic [11:0] al);
    bus.tick = t; bus.mode = m; bus.req = r;
    bus.bcd_mile = mi; bus.bcd_speed = sp; bus.bcd_alert = al;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [13:0] e;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 2'b00, 3'b000, 12'h000, 12'h000, 12'h000);

    //  tick mode   req     mile     speed    alert    gnt     an      seg
    // mileage 042 granted, digits cycle 2 / 4 / blank, hold then keep
    add(0, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b000, 3'b000, 8'h00);
    add(0, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b001, 8'h5B);
    add(0, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b001, 8'h5B);
    add(1, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(1, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b100, 8'h00);
    add(1, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b001, 8'h5B);
    add(1, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(0, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b001, 8'h5B);
    // req drops after one tick, mileage moves to 043: "42" frozen until expiry, then IDLE
    add(1, 2'b01, 3'b001, 12'h042, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(1, 2'b01, 3'b000, 12'h043, 12'h056, 12'h000, 3'b001, 3'b100, 8'h00);
    add(1, 2'b01, 3'b000, 12'h043, 12'h056, 12'h000, 3'b001, 3'b001, 8'h5B);
    add(1, 2'b01, 3'b000, 12'h043, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(0, 2'b01, 3'b000, 12'h043, 12'h056, 12'h000, 3'b000, 3'b000, 8'h00);
    add(0, 2'b01, 3'b000, 12'h043, 12'h056, 12'h000, 3'b000, 3'b000, 8'h00);
    // speed and mileage both held: speed first, alternating every 4 ticks
    add(0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b001, 8'h7D);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b010, 8'h6D);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b100, 8'h00);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b001, 8'h7D);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b010, 8'h6D);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b001, 3'b001, 8'h4F);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b001, 3'b100, 8'h00);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b001, 3'b001, 8'h4F);
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b001, 3'b010, 8'h66);
    add(0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b001, 8'h7D);
    // alert 007 preempts speed at tick 1 of its hold, shows on ones only
    add(1, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000, 3'b010, 3'b010, 8'h6D);
    add(0, 2'b01, 3'b111, 12'h043, 12'h056, 12'h007, 3'b100, 3'b001, 8'h07);
    add(1, 2'b01, 3'b111, 12'h043, 12'h056, 12'h007, 3'b100, 3'b010, 8'h00);
    add(1, 2'b01, 3'b111, 12'h043, 12'h056, 12'h007, 3'b100, 3'b100, 8'h00);
    add(1, 2'b01, 3'b111, 12'h043, 12'h056, 12'h007, 3'b100, 3'b001, 8'h07);
    add(1, 2'b01, 3'b111, 12'h043, 12'h056, 12'h007, 3'b100, 3'b010, 8'h00);
    // alert expires with speed and mileage pending: speed was last, so mileage
    add(0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h007, 3'b001, 3'b001, 8'h4F);
    // car off mid-SHOW, then on again: IDLE, then fixed-priority speed
    add(0, 2'b00, 3'b011, 12'h043, 12'h056, 12'h007, 3'b000, 3'b000, 8'h00);
    add(0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h007, 3'b000, 3'b000, 8'h00);
    add(0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h007, 3'b010, 3'b001, 8'h7D);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset gnt", 16'(bus.gnt), 16'h0);
    check("reset an", 16'(bus.an), 16'h0);
    check("reset seg", 16'(bus.led_seg), 16'h0);
    check("reset state", 16'(bus.dbg_state), 16'(OFF));
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].tick, vecs[i].mode, vecs[i].req, vecs[i].mile, vecs[i].speed, vecs[i].alert);
      exp_q.push_back({vecs[i].gnt, vecs[i].an, vecs[i].seg});
      step();
      e = exp_q.pop_front();
      check($sformatf("v%0d gnt", i), 16'(bus.gnt), 16'(e[13:11]));
      check($sformatf("v%0d an", i), 16'(bus.an), 16'(e[10:8]));
      check($sformatf("v%0d seg", i), 16'(bus.led_seg), 16'(e[7:0]));
      check($sformatf("v%0d onehot", i), 16'($countones(bus.gnt) <= 1), 16'd1);
    end

    // asynchronous reset between clock edges while showing speed
    rst = 1'b1;
    #1;
    check("async rst gnt", 16'(bus.gnt), 16'h0);
    check("async rst an", 16'(bus.an), 16'h0);
    check("async rst seg", 16'(bus.led_seg), 16'h0);
    check("async rst state", 16'(bus.dbg_state), 16'(OFF));
    @(negedge clk);
    rst = 1'b0;

    // HOLD_TICKS=0 behaves as 1: one tick of hold, then rotate to mileage
    drive(1'b0, 2'b01, 3'b011, 12'h043, 12'h056, 12'h000);
    step();
    check("h0 idle state", 16'(bus0.dbg_state), 16'(IDLE));
    step();
    check("h0 grant speed", 16'(bus0.gnt), 16'h2);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("h0 hold speed", 16'(bus0.gnt), 16'h2);
    step();
    check("h0 rotate gnt", 16'(bus0.gnt), 16'h1);
    check("h0 rotate seg", 16'(bus0.led_seg), 16'h4F);
    check("h4 still speed", 16'(bus.gnt), 16'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
